// File: rtl/ohsm_sequencer_if.sv
// Step interface between the sequencer, its run controller and the ohsm block.
interface ohsm_sequencer_if;
  logic       go;
  logic [3:0] ValorEstado;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [3:0] step_cnt;
  logic [3:0] expected;

  // Sequencer side
  modport master (
    input  go, ValorEstado,
    output start, busy, done, error, err_code, step_cnt, expected
  );

  // Controller / ohsm side
  modport slave (
    output go, ValorEstado,
    input  start, busy, done, error, err_code, step_cnt, expected
  );
endinterface

// File: rtl/ohsm_sequencer.sv
// ohsm_sequencer: pulses start to step the one-hot ohsm, checks every advance is the
// next left rotation within TIMEOUT cycles, and reports completion or a coded error.
module ohsm_sequencer #(
  parameter int unsigned STEPS   = 4,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 8
) (
  input logic              clk,
  input logic              reset,
  ohsm_sequencer_if.master bus
);

  localparam logic [3:0] StepsW   = 4'(STEPS);
  localparam logic [3:0] GapW     = 4'(GAP);
  localparam logic [3:0] TimeoutW = 4'(TIMEOUT);

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrOneHot  = 2'b01;
  localparam logic [1:0] ErrTrans   = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  typedef enum logic [2:0] {StIdle, StPulse, StWait, StGap, StDone, StErr} state_e;

  function automatic logic is_onehot(input logic [3:0] x);
    return (x != 4'b0000) && ((x & (x - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction

  state_e     state_q, state_d;
  logic       go_q;
  logic [3:0] expected_q, expected_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] step_cnt_q, step_cnt_d;
  logic [3:0] timer_q, timer_d;
  logic [3:0] gap_q, gap_d;
  logic [1:0] err_code_q, err_code_d;
  logic       start_q, busy_q, done_q, error_q;
  logic       go_rise, ve_onehot;

  assign go_rise   = bus.go & ~go_q;
  assign ve_onehot = is_onehot(bus.ValorEstado);

  // Next-state and datapath updates for the run sequencing FSM
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    prev_d     = prev_q;
    step_cnt_d = step_cnt_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    err_code_d = err_code_q;
    unique case (state_q)
      StIdle: begin
        if (go_rise) begin
          if (ve_onehot) begin
            expected_d = rotl(bus.ValorEstado);
            prev_d     = bus.ValorEstado;
            step_cnt_d = 4'd0;
            err_code_d = ErrNone;
            state_d    = StPulse;
          end else begin
            err_code_d = ErrOneHot;
            state_d    = StErr;
          end
        end
      end
      StPulse: begin
        timer_d = 4'd1;
        state_d = StWait;
      end
      StWait: begin
        // Check order matters: a match on the final timer cycle still succeeds.
        if (!ve_onehot) begin
          err_code_d = ErrOneHot;
          state_d    = StErr;
        end else if (bus.ValorEstado == expected_q) begin
          step_cnt_d = step_cnt_q + 4'd1;
          prev_d     = expected_q;
          if (step_cnt_d == StepsW) begin
            state_d = StDone;
          end else if (GAP == 0) begin
            expected_d = rotl(expected_q);
            state_d    = StPulse;
          end else begin
            gap_d   = 4'd1;
            state_d = StGap;
          end
        end else if (bus.ValorEstado != prev_q) begin
          err_code_d = ErrTrans;
          state_d    = StErr;
        end else if (timer_q == TimeoutW) begin
          err_code_d = ErrTimeout;
          state_d    = StErr;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      StGap: begin
        // Any movement here happened without a start pulse.
        if (bus.ValorEstado != prev_q) begin
          err_code_d = ErrTrans;
          state_d    = StErr;
        end else if (gap_q == GapW) begin
          expected_d = rotl(expected_q);
          state_d    = StPulse;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StErr: begin
        if (!bus.go) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register; flags are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      go_q       <= 1'b0;
      expected_q <= 4'd0;
      prev_q     <= 4'd0;
      step_cnt_q <= 4'd0;
      timer_q    <= 4'd0;
      gap_q      <= 4'd0;
      err_code_q <= ErrNone;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      go_q       <= bus.go;
      expected_q <= expected_d;
      prev_q     <= prev_d;
      step_cnt_q <= step_cnt_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      err_code_q <= err_code_d;
      start_q    <= (state_d == StPulse);
      busy_q     <= (state_d inside {StPulse, StWait, StGap});
      done_q     <= (state_d == StDone);
      error_q    <= (state_d == StErr);
    end
  end

  assign bus.start    = start_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;
  assign bus.err_code = err_code_q;
  assign bus.step_cnt = step_cnt_q;
  assign bus.expected = expected_q;

endmodule

// File: tb/tb_ohsm_sequencer.sv
// Bench for ohsm_sequencer: behavioural ohsm responder, table of run scenarios,
// hand sequences for reset, go handling, injected faults and a GAP=0 instance.
module tb_ohsm_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ohsm_sequencer_if sif ();
  ohsm_sequencer_if sif0 ();

  ohsm_sequencer #(.STEPS(4), .GAP(2), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  ohsm_sequencer #(.STEPS(3), .GAP(0), .TIMEOUT(8)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (sif0)
  );

  int total = 0;
  int bad   = 0;
  logic [3:0] sb_q[$];

  function automatic logic [3:0] rotl(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction

  function automatic logic [3:0] nxt(input logic [3:0] x, input logic w);
    return w ? rotl(rotl(x)) : rotl(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ohsm model: advances m_delay cycles after start (from step m_slow_from on)
  logic [3:0] model_q, m_init, ovr_val;
  logic       m_load, m_wrong, ovr_en;
  int         m_delay, m_slow_from, cnt, m_idx;

  always @(posedge clk) begin
    if (m_load) begin
      model_q <= m_init;
      cnt     <= 0;
      m_idx   <= 0;
    end else if (sif.start) begin
      m_idx <= m_idx + 1;
      if (((m_idx >= m_slow_from) ? m_delay : 1) <= 1) model_q <= nxt(model_q, m_wrong);
      else cnt <= ((m_idx >= m_slow_from) ? m_delay : 1) - 1;
    end else if (cnt != 0) begin
      if (cnt == 1) model_q <= nxt(model_q, m_wrong);
      cnt <= cnt - 1;
    end
  end
  assign sif.ValorEstado = ovr_en ? ovr_val : model_q;

  // Responsive ohsm for the GAP=0 instance
  logic [3:0] ve0;
  always @(posedge clk) begin
    if (!reset) ve0 <= 4'b0001;
    else if (sif0.start) ve0 <= rotl(ve0);
  end
  assign sif0.ValorEstado = ve0;

  typedef struct {
    string      name;
    logic [3:0] init;
    int         delay;
    int         slow_from;
    bit         wrong;
    bit         exp_err;
    logic [1:0] exp_code;
    logic [3:0] exp_cnt;
    int         exp_pulses;
    int         exp_len;
  } vec_t;

  function automatic vec_t mk(string n, logic [3:0] i, int d, int sf, bit w, bit ee,
                              logic [1:0] ec, logic [3:0] c, int p, int l);
    vec_t v;
    v.name = n; v.init = i; v.delay = d; v.slow_from = sf; v.wrong = w;
    v.exp_err = ee; v.exp_code = ec; v.exp_cnt = c; v.exp_pulses = p; v.exp_len = l;
    return v;
  endfunction

  task automatic load_model(input logic [3:0] init, input int d, input int sf, input bit w);
    m_init = init; m_delay = d; m_slow_from = sf; m_wrong = w;
    m_load = 1'b1;
    @(negedge clk);
    m_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (sif.start) found = 1;
    end
    check({name, " start seen"}, found, 1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] x;
    int t = 0, t_busy = -1, t_done = -1, last = 0, pulses = 0;
    bit fin = 0, saw_err = 0;
    load_model(v.init, v.delay, v.slow_from, v.wrong);
    x = v.init;
    sb_q.delete();
    for (int i = 0; i < v.exp_pulses; i++) begin
      x = rotl(x);
      sb_q.push_back(x);
    end
    sif.go = 1'b1;
    while (!fin && t < 300) begin
      @(negedge clk);
      t++;
      if (sif.busy && t_busy < 0) t_busy = t;
      if (sif.start) begin
        if (!v.exp_err && pulses > 0)
          check({v.name, " start period"}, t - last,
                ((pulses - 1 >= v.slow_from) ? v.delay : 1) + 1 + 2);
        last = t;
        pulses++;
        if (sb_q.size() == 0) check({v.name, " extra start"}, sif.start, 0);
        else check({v.name, " expected"}, sif.expected, sb_q.pop_front());
      end
      if (sif.done) begin fin = 1; t_done = t; end
      if (sif.error) begin fin = 1; saw_err = 1; end
    end
    check({v.name, " finished"}, fin, 1);
    check({v.name, " error"}, saw_err, v.exp_err);
    check({v.name, " err_code"}, sif.err_code, v.exp_code);
    check({v.name, " step_cnt"}, sif.step_cnt, v.exp_cnt);
    check({v.name, " pulses"}, pulses, v.exp_pulses);
    if (!v.exp_err) check({v.name, " run length"}, t_done - t_busy, v.exp_len);
    sb_q.delete();
    if (v.exp_err) begin
      @(negedge clk);
      check({v.name, " error held"}, sif.error, 1);
      sif.go = 1'b0;
      @(negedge clk);
      check({v.name, " error cleared"}, sif.error, 0);
      check({v.name, " code held"}, sif.err_code, v.exp_code);
    end else begin
      sif.go = 1'b0;
      @(negedge clk);
      check({v.name, " done one cycle"}, sif.done, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];

  initial begin
    int t, tb, td, last, n;
    bit flag;
    logic [3:0] x;

    vecs[0] = mk("nominal",      4'b0001, 1, 0, 0, 0, 2'b00, 4'd4, 4, 14);
    vecs[1] = mk("from_1000",    4'b1000, 1, 0, 0, 0, 2'b00, 4'd4, 4, 14);
    vecs[2] = mk("delay3",       4'b0001, 3, 0, 0, 0, 2'b00, 4'd4, 4, 22);
    vecs[3] = mk("slow8",        4'b0001, 8, 0, 0, 0, 2'b00, 4'd4, 4, 42);
    vecs[4] = mk("timeout9",     4'b0001, 9, 0, 0, 1, 2'b11, 4'd0, 1, 0);
    vecs[5] = mk("late_timeout", 4'b0001, 9, 2, 0, 1, 2'b11, 4'd2, 3, 0);
    vecs[6] = mk("wrong_jump",   4'b0001, 1, 0, 1, 1, 2'b10, 4'd0, 1, 0);
    vecs[7] = mk("illegal_0011", 4'b0011, 1, 0, 0, 1, 2'b01, 4'd0, 0, 0);

    reset = 1'b0; sif.go = 1'b0; sif0.go = 1'b0; ovr_en = 1'b0; ovr_val = 4'b0000;
    m_init = 4'b0001; m_delay = 1; m_slow_from = 0; m_wrong = 1'b0; m_load = 1'b1;
    repeat (3) @(negedge clk);
    check("reset start", sif.start, 0);
    check("reset busy", sif.busy, 0);
    check("reset done", sif.done, 0);
    check("reset error", sif.error, 0);
    check("reset err_code", sif.err_code, 2'b00);
    check("reset step_cnt", sif.step_cnt, 4'd0);
    check("reset expected", sif.expected, 4'b0000);
    reset = 1'b1; m_load = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Advance during GAP without a start pulse
    load_model(4'b0001, 1, 0, 0);
    sif.go = 1'b1;
    wait_start("spurious");
    @(negedge clk);
    @(negedge clk);
    check("spurious in gap", sif.busy & ~sif.start, 1);
    ovr_val = 4'b0100; ovr_en = 1'b1;
    @(negedge clk);
    check("spurious error", sif.error, 1);
    check("spurious code", sif.err_code, 2'b10);
    check("spurious step_cnt", sif.step_cnt, 4'd1);
    ovr_en = 1'b0; sif.go = 1'b0;
    repeat (2) @(negedge clk);

    // 0000 appearing while waiting
    load_model(4'b0001, 5, 0, 0);
    sif.go = 1'b1;
    wait_start("zero");
    @(negedge clk);
    ovr_val = 4'b0000; ovr_en = 1'b1;
    @(negedge clk);
    check("zero error", sif.error, 1);
    check("zero code", sif.err_code, 2'b01);
    ovr_en = 1'b0; sif.go = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted in the PULSE cycle
    load_model(4'b0001, 1, 0, 0);
    sif.go = 1'b1;
    wait_start("rst");
    reset = 1'b0;
    @(negedge clk);
    check("rst start", sif.start, 0);
    check("rst busy", sif.busy, 0);
    check("rst done", sif.done, 0);
    check("rst error", sif.error, 0);
    check("rst err_code", sif.err_code, 2'b00);
    check("rst step_cnt", sif.step_cnt, 4'd0);
    check("rst expected", sif.expected, 4'b0000);
    reset = 1'b1; sif.go = 1'b0;
    flag = 0;
    repeat (4) begin
      @(negedge clk);
      if (sif.done || sif.error || sif.start || sif.busy) flag = 1;
    end
    check("rst quiet after", flag, 0);

    // go held high through DONE must not restart
    load_model(4'b0001, 1, 0, 0);
    sif.go = 1'b1;
    flag = 0;
    for (int i = 0; i < 40 && !flag; i++) begin
      @(negedge clk);
      if (sif.done) flag = 1;
    end
    check("held done seen", flag, 1);
    flag = 0;
    repeat (8) begin
      @(negedge clk);
      if (sif.start || sif.busy) flag = 1;
    end
    check("held no restart", flag, 0);
    check("held step_cnt", sif.step_cnt, 4'd4);
    sif.go = 1'b0;
    @(negedge clk);
    sif.go = 1'b1;
    @(negedge clk);
    check("rerun start", sif.start, 1);
    check("rerun step_cnt cleared", sif.step_cnt, 4'd0);
    flag = 0;
    for (int i = 0; i < 40 && !flag; i++) begin
      @(negedge clk);
      if (sif.done) flag = 1;
    end
    check("rerun done seen", flag, 1);
    check("rerun step_cnt", sif.step_cnt, 4'd4);
    sif.go = 1'b0;
    @(negedge clk);

    // GAP=0 instance: back-to-back steps
    x = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      x = rotl(x);
      sb_q.push_back(x);
    end
    sif0.go = 1'b1;
    t = 0; tb = -1; td = -1; last = 0; n = 0;
    while (td < 0 && t < 60) begin
      @(negedge clk);
      t++;
      if (sif0.busy && tb < 0) tb = t;
      if (sif0.start) begin
        if (n > 0) check("gap0 period", t - last, 2);
        last = t;
        n++;
        if (sb_q.size() == 0) check("gap0 extra start", sif0.start, 0);
        else check("gap0 expected", sif0.expected, sb_q.pop_front());
      end
      if (sif0.done) td = t;
    end
    check("gap0 done seen", td >= 0, 1);
    check("gap0 run length", td - tb, 6);
    check("gap0 pulses", n, 3);
    check("gap0 step_cnt", sif0.step_cnt, 4'd3);
    check("gap0 err_code", sif0.err_code, 2'b00);
    sif0.go = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
